// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial deserializer.
package serial_pkg;

    // Receive FSM states; StParity is only reachable in the parity build.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2
    } state_e;

    // Bits needed to count 0..width received bits.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer, LSB first, with a valid/ready output register
// and a sticky overrun flag. Optional even-parity bit when SERIAL_DESER_PARITY_EN
// is defined; otherwise parity_err is constant 0 and no parity bit is expected.
module serial_deserializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic             parity_err
);
    import serial_pkg::*;

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;

    logic             word_done;
    logic [WIDTH-1:0] word;
    logic             word_perr;
    logic [WIDTH-1:0] shifted;

    // New bit enters at the MSB so the first bit ends up in bit 0.
    assign shifted = {serial_in, shift_q[WIDTH-1:1]};

    // Receive FSM, output register and overrun next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        perr_d    = perr_q;
        word_done = 1'b0;
        word      = shifted;
        word_perr = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (serial_valid) begin
                    shift_d = shifted;
                    cnt_d   = CntW'(1);
                    state_d = StData;
                end
            end
            StData: begin
                if (serial_valid) begin
                    shift_d = shifted;
                    if (cnt_q == LastCnt) begin
`ifdef SERIAL_DESER_PARITY_EN
                        cnt_d   = CntW'(WIDTH);
                        state_d = StParity;
`else
                        word_done = 1'b1;
                        word      = shifted;
                        cnt_d     = '0;
                        state_d   = StIdle;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
`ifdef SERIAL_DESER_PARITY_EN
                if (serial_valid) begin
                    // Even parity: data XOR parity bit must be 0.
                    word_done = 1'b1;
                    word      = shift_q;
                    word_perr = (^shift_q) ^ serial_in;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end
`else
                cnt_d   = '0;
                state_d = StIdle;
`endif
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        // A completing word is dropped only if the held word is not leaving this cycle.
        if (word_done) begin
            if (valid_q && !data_ready) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = word;
                perr_d  = word_perr;
                valid_d = 1'b1;
            end
        end

        // Clear wins over everything, including a bit sampled this cycle.
        if (clear) begin
            state_d = StIdle;
            cnt_d   = '0;
            shift_d = shift_q;
            data_d  = data_q;
            perr_d  = perr_q;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (WIDTH=8). Inputs change and outputs are
// sampled 1 time unit after the rising edge. Parity checks only in the
// SERIAL_DESER_PARITY_EN build.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b0;
    logic       serial_valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       overrun;
    logic       parity_err;

    int n_checks = 0;
    int n_fail   = 0;

    serial_deserializer #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .clear        (clear),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .overrun      (overrun),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    // Drive bits w[lo..hi] on consecutive cycles, sampled at each rising edge.
    task automatic send_bits(input logic [7:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            serial_in    = w[i];
            serial_valid = 1'b1;
            @(posedge clk); #1;
        end
        serial_valid = 1'b0;
    endtask

    // Every serial bit of a word except the completing one.
    task automatic send_open(input logic [7:0] w);
`ifdef SERIAL_DESER_PARITY_EN
        send_bits(w, 0, 7);
`else
        send_bits(w, 0, 6);
`endif
    endtask

    // The completing serial bit (bit 7, or the even-parity bit).
    task automatic send_final(input logic [7:0] w);
        logic [7:0] t;
`ifdef SERIAL_DESER_PARITY_EN
        t = {7'd0, ^w};
        send_bits(t, 0, 0);
`else
        t = w;
        send_bits(t, 7, 7);
`endif
    endtask

    task automatic send_word(input logic [7:0] w);
        send_open(w);
        send_final(w);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_out); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        data_ready = 1'b1;
        send_open(8'hA5);
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b want 0", data_valid); end
        send_final(8'hA5);
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", data_valid); end
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", data_out); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b want 0", parity_err); end
        @(posedge clk); #1;
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b want 0", data_valid); end
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        send_word(8'h3C);
        n_checks++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL ovr_first: got %h want 3c", data_out); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_not_yet: got %b want 0", overrun); end
        send_word(8'h81);
        n_checks++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL ovr_held: got %h want 3c", data_out); end
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", data_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        data_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consumed: got %b want 0", data_valid); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        pulse_clear();
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_back_to_back();
        data_ready = 1'b0;
        send_word(8'h0F);
        n_checks++; if (data_out !== 8'h0F) begin n_fail++; $display("FAIL b2b_first: got %h want 0f", data_out); end
        send_open(8'hF0);
        data_ready = 1'b1;
        send_final(8'hF0);
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", data_valid); end
        n_checks++; if (data_out !== 8'hF0) begin n_fail++; $display("FAIL b2b_data: got %h want f0", data_out); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        @(posedge clk); #1;
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", data_valid); end
    endtask

    task automatic test_gap();
        data_ready = 1'b1;
        send_bits(8'h5A, 0, 3);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL gap_idle: got %b want 0", data_valid); end
        send_bits(8'h5A, 4, 6);
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early: got %b want 0", data_valid); end
`ifdef SERIAL_DESER_PARITY_EN
        send_bits(8'h5A, 7, 7);
`endif
        send_final(8'h5A);
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid: got %b want 1", data_valid); end
        n_checks++; if (data_out !== 8'h5A) begin n_fail++; $display("FAIL gap_data: got %h want 5a", data_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        data_ready = 1'b1;
        send_bits(8'hFF, 0, 3);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL async_rst_data: got %h want 00", data_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        send_word(8'hC3);
        n_checks++; if (data_out !== 8'hC3) begin n_fail++; $display("FAIL rst_resync: got %h want c3", data_out); end
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL rst_resync_valid: got %b want 1", data_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_clear();
        data_ready = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL clr_setup_ovr: got %b want 1", overrun); end
        data_ready = 1'b1;
        send_bits(8'hFF, 0, 3);
        // Clear with serial_valid high: that bit must be ignored.
        serial_in    = 1'b1;
        serial_valid = 1'b1;
        pulse_clear();
        serial_valid = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL clr_overrun: got %b want 0", overrun); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", data_valid); end
        send_word(8'hC3);
        n_checks++; if (data_out !== 8'hC3) begin n_fail++; $display("FAIL clr_resync: got %h want c3", data_out); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL clr_resync_ovr: got %b want 0", overrun); end
        @(posedge clk); #1;
    endtask

`ifdef SERIAL_DESER_PARITY_EN
    task automatic test_parity();
        logic [7:0] p;
        data_ready = 1'b1;
        p = 8'h01;
        send_bits(8'h07, 0, 7);
        send_bits(p, 0, 0);
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL par_good: got %b want 0", parity_err); end
        n_checks++; if (data_out !== 8'h07) begin n_fail++; $display("FAIL par_data: got %h want 07", data_out); end
        p = 8'h00;
        send_bits(8'h07, 0, 7);
        send_bits(p, 0, 0);
        n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL par_bad: got %b want 1", parity_err); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_gap();
        test_mid_reset();
        test_mid_clear();
`ifdef SERIAL_DESER_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
